// File: rtl/fifo_feed_ctrl.sv
// fifo_feed_ctrl: load/feed/drain sequencer for the systolic-array lane FIFOs.
// Define FEEDCTRL_PERF_EN to build the perf_cycles job-length counter.
module fifo_feed_ctrl #(
  parameter int DIM = 8,
  parameter int CW  = $clog2(DIM)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic           load_valid,
  output logic           load_ready,
  output logic [CW-1:0]  load_lane,
  output logic [DIM-1:0] fifo_en,
  output logic           feed_sel,
  output logic           array_en,
  output logic           busy,
  output logic           done,
  output logic [31:0]    perf_cycles
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FEED, S_DRAIN, S_DONE} state_t;

  // One extra bit on the step counter covers the 2*DIM-1 feed steps.
  localparam int            SW         = CW + 1;
  localparam logic [CW-1:0] LAST_IDX   = CW'(DIM - 1);
  localparam logic [SW-1:0] LAST_STEP  = SW'(2 * DIM - 2);
  localparam logic [SW-1:0] LAST_DRAIN = SW'(DIM - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] word_cnt;
  logic [CW-1:0] lane_cnt;
  logic [SW-1:0] step_cnt;
  logic          load_xfer;
  logic          load_last;
  logic          feed_last;
  logic          drain_last;

  assign load_xfer  = (state == S_LOAD) && load_valid;
  assign load_last  = load_xfer && (word_cnt == LAST_IDX) && (lane_cnt == LAST_IDX);
  assign feed_last  = (state == S_FEED) && (step_cnt == LAST_STEP);
  assign drain_last = (state == S_DRAIN) && (step_cnt == LAST_DRAIN);

  assign load_lane = lane_cnt;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    feed_sel   = 1'b0;
    array_en   = 1'b0;
    fifo_en    = '0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        load_ready = 1'b1;
        for (int l = 0; l < DIM; l++) fifo_en[l] = load_valid && (int'(lane_cnt) == l);
        if (abort)          state_nxt = S_IDLE;
        else if (load_last) state_nxt = S_FEED;
      end
      S_FEED: begin
        feed_sel = 1'b1;
        array_en = 1'b1;
        // Lane l shifts during steps l..l+DIM-1, giving the diagonal skew.
        for (int l = 0; l < DIM; l++)
          fifo_en[l] = (int'(step_cnt) >= l) && (int'(step_cnt) < l + DIM);
        if (abort)          state_nxt = S_IDLE;
        else if (feed_last) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        array_en = 1'b1;
        if (abort)           state_nxt = S_IDLE;
        else if (drain_last) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Every state change restarts the counters, so load_lane is 0 outside LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= '0;
      lane_cnt <= '0;
      step_cnt <= '0;
    end else if (state_nxt != state) begin
      word_cnt <= '0;
      lane_cnt <= '0;
      step_cnt <= '0;
    end else if (load_xfer) begin
      if (word_cnt == LAST_IDX) begin
        word_cnt <= '0;
        lane_cnt <= lane_cnt + CW'(1);
      end else begin
        word_cnt <= word_cnt + CW'(1);
      end
    end else if (state == S_FEED || state == S_DRAIN) begin
      step_cnt <= step_cnt + SW'(1);
    end
  end

`ifdef FEEDCTRL_PERF_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt <= '0;
    end else if (state == S_IDLE && start) begin
      perf_cnt <= '0;
    end else if ((state == S_LOAD || state == S_FEED || state == S_DRAIN) && (perf_cnt != '1)) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end

  assign perf_cycles = perf_cnt;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: doc/fifo_feed_ctrl.md
# fifo_feed_ctrl

Sequencing controller for the per-lane delay FIFOs that feed the systolic multiply array. It loads DIM words into each of DIM lane FIFOs through a valid/ready port, then shifts the lanes out with a one-cycle-per-lane skew while enabling the array, and drains the array before signalling completion. It sits between the CCI-P MMIO/load logic and the FIFO bank. It owns only control signals: data goes straight into each FIFO's `d` through a mux that this block steers with `feed_sel`.

## Interface
- `DIM`, default 8 — number of lanes. Also the depth of each lane FIFO. Legal range 2..64.
- `CW`, default `$clog2(DIM)` — width of the lane index.
- `clk` in, 1 — clock; all state changes on the rising edge.
- `rst_n` in, 1 — reset, asynchronous, active-low.
- `start` in, 1 — job request; accepted only in IDLE.
- `abort` in, 1 — cancel the current job; effective in any non-IDLE state.
- `load_valid` in, 1 — a load word is present on the FIFO data bus.
- `load_ready` out, 1 — controller accepts a load word this cycle.
- `load_lane` out, CW — lane that receives the current load word.
- `fifo_en` out, DIM — per-lane FIFO shift enable.
- `feed_sel` out, 1 — 0: FIFO `d` takes load data; 1: FIFO `d` takes zero.
- `array_en` out, 1 — systolic array advance enable.
- `busy` out, 1 — high whenever the state is not IDLE.
- `done` out, 1 — one-cycle completion pulse.
- `perf_cycles` out, 32 — active-cycle count of the last or current job.

## Operation
States are IDLE, LOAD, FEED, DRAIN and DONE. Reset puts the block in IDLE with every output 0 and all counters 0.

**IDLE**
- `load_ready`, `fifo_en`, `array_en` and `feed_sel` are all 0.
- `start`=1 moves to LOAD and clears the word, lane and step counters.

**LOAD**
- `load_ready`=1 and `feed_sel`=0.
- A transfer happens when `load_valid & load_ready`. On a transfer, `fifo_en` = one-hot(`load_lane`); this path is combinational from `load_valid`.
- The word counter runs 0..DIM-1. When it wraps, `load_lane` increments.
- After transfer number DIM*DIM, the block moves to FEED.
- When `load_valid`=0, `fifo_en`=0 and the counters hold.

**FEED**
- The step counter `t` runs 0..2*DIM-2.
- `fifo_en[l]` = 1 iff l ≤ t < l+DIM, so each lane gets exactly DIM shifts.
- `feed_sel`=1, `array_en`=1 and `load_ready`=0.
- After t=2*DIM-2, the block moves to DRAIN.

**DRAIN**
- `array_en`=1 and `fifo_en`=0 for DIM cycles, then the block moves to DONE.

**DONE**
- `done`=1 for exactly one cycle, then the block returns to IDLE.
- `busy` is still 1 in this cycle.

**Boundary and priority rules**
- `abort` has priority over every other transition. In LOAD, FEED or DRAIN it forces IDLE on the next edge. No `done` is produced, and FIFO contents are left as they are.
- `abort` in IDLE does nothing.
- `start` outside IDLE is ignored. That includes the DONE cycle.
- `abort` and `start` together in IDLE: `start` wins.
- `load_lane` returns to 0 on leaving LOAD.
- `fifo_en`, `array_en`, `feed_sel` and `load_ready` are decoded from the registered state and counters, with `load_valid` as the only combinational input.

## Timing
- Cycle 0 is `start` in IDLE. LOAD begins at cycle 1, where `load_ready` first goes high.
- With `load_valid` held high and DIM=8:
  - LOAD occupies cycles 1..64.
  - FEED occupies cycles 65..79.
  - DRAIN occupies cycles 80..87.
  - DONE is cycle 88; IDLE resumes at cycle 89.
- In general, FEED lasts 2*DIM-1 cycles and DRAIN lasts DIM cycles. Each LOAD stall cycle (`load_valid`=0) adds exactly one cycle.
- Asynchronous reset at any point forces IDLE immediately and zeroes all outputs, including `perf_cycles`.

## Configuration
- Macro `FEEDCTRL_PERF_EN`.
- **Defined:**
  - `perf_cycles` clears when `start` is accepted.
  - It increments in every LOAD, FEED or DRAIN cycle and saturates at 2^32-1.
  - It holds its value in DONE and IDLE.
  - On `abort` it keeps the partial count.
- **Undefined:** `perf_cycles` is tied to 0 and no counter logic is built.

## Test plan
- **Reset:** assert `rst_n`=0 mid-LOAD.
  - Outputs: all go to 0 asynchronously, with `load_ready`=0.
  - After release: block is in IDLE; `start` restarts the job from lane 0.
- **Full job, DIM=8:** `load_valid` held at 1.
  - `load_lane` = k/8 for transfer k.
  - `fifo_en[3]` is high in cycles 68..75.
  - `array_en` is high in cycles 65..87.
  - `done` pulses at cycle 88.
  - `perf_cycles` = 87 with the macro defined, 0 without it.
- **Backpressure:** `load_valid` alternates 1,0.
  - `fifo_en` is 0 in every cycle where `load_valid`=0.
  - Each lane sees exactly 8 load shifts.
  - `done` arrives at cycle 152.
- **Abort:** `abort` at FEED step t=5.
  - Next cycle: IDLE, with `fifo_en`=0 and `array_en`=0.
  - `done` never pulses.
  - `perf_cycles` = 70 with the macro defined.
- **Start collisions:**
  - `start` pulsed during FEED and during the DONE cycle is ignored; state and counters are unchanged.
  - `start` and `abort` together in IDLE enter LOAD.
